cnn_pool_relu_stream: RTL and testbench
=======================================

# cnn_pool_relu_stream

Downstream stage of the CNN core: accepts one complete flattened output feature map (all OCH channels, OX×OY accumulators each) in a single-cycle valid pulse and stores it in an internal buffer. It then applies 2×2 stride-2 max pooling followed by ReLU. Pooled results are streamed out one element per beat over a valid/ready handshake. It decouples the core's wide, one-shot result bus from narrow consumers such as the next layer's input buffer or a result FIFO.

## Interface
- `OCH`, default 2: output channels in the captured map.
- `OX`, default 4: map width; must be even.
- `OY`, default 4: map height; must be even.
- `DATA_LEN`, default 20: element width, signed two's complement.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `i_soft_reset`, input, 1: synchronous, active-high; same effect as `reset`.
- `i_in_valid`, input, 1: input map present; a capture occurs only when `o_in_ready`=1.
- `i_in_fmap`, input, OCH*OX*OY*DATA_LEN: element (c,y,x) sits at bits [((c*OY+y)*OX+x)*DATA_LEN +: DATA_LEN].
- `o_in_ready`, output, 1: 1 in IDLE only.
- `o_ot_valid`, output, 1: `o_ot_data` holds a valid pooled element.
- `i_ot_ready`, input, 1: consumer accepts a beat.
- `o_ot_data`, output, DATA_LEN: pooled, ReLU'd element; always ≥ 0.
- `o_ot_last`, output, 1: marks the final beat of the map.
- `o_busy`, output, 1: 1 in RUN.

## Operation
- Two states:
  - IDLE (reset state).
  - RUN.
- IDLE:
  - `o_in_ready`=1.
  - On `i_in_valid`: register the whole `i_in_fmap` into the buffer, clear counters c/py/px to 0, and go to RUN.
- RUN:
  - `o_in_ready`=0; `i_in_valid` is ignored and the buffer is never overwritten.
  - `o_ot_valid`=1.
  - `o_ot_data` = max(0, max of elements (c,2py,2px), (c,2py,2px+1), (c,2py+1,2px), (c,2py+1,2px+1)), compared as signed values.
  - `o_ot_data` is derived combinationally from the buffer and counter registers only; there is no input-to-output combinational path.
- Beat transfer is `o_ot_valid & i_ot_ready`. On each transfer:
  - px increments.
  - When px reaches OX/2-1, px wraps to 0 and py increments.
  - When py reaches OY/2-1, py wraps to 0 and c increments.
- Order is channel-major: px innermost, then py, then c.
- `o_ot_last`=1 when c=OCH-1, py=OY/2-1 and px=OX/2-1. A transfer while `o_ot_last`=1 returns the block to IDLE.
- Total beats per map: OCH*(OX/2)*(OY/2), i.e. 8 with the defaults.
- Stall: while `i_ot_ready`=0, counters hold and `o_ot_data`/`o_ot_last` stay stable.
- ReLU: a negative max outputs 0. The most-negative value −2^(DATA_LEN−1) is handled with no overflow (pure compare/select, no arithmetic).

## Timing
- Reset values:
  - `o_in_ready`=1.
  - `o_ot_valid`=0, `o_ot_last`=0, `o_busy`=0.
  - `o_ot_data`=0.
  - Counters 0; buffer 0.
- Latency: input captured at edge N, so the first beat is valid in cycle N+1. With `i_ot_ready` held high, beats run in consecutive cycles and the last is in cycle N+8 (default parameters).
- Back-to-back maps:
  - The final transfer returns the block to IDLE, so `o_in_ready`=1 in the next cycle.
  - Minimum map-to-map interval: 8+1 cycles.
- `reset`/`i_soft_reset` priority:
  - Either one wins over every other event, including a simultaneous `i_in_valid` or transfer.
  - Asserting it mid-RUN returns the block to IDLE at that edge; `o_ot_valid`=0 in the following cycle and the partial map is discarded.
- `i_in_valid` asserted in RUN is neither captured nor queued; upstream must hold or re-present the map.

## Structure
- Shared defines header holds:
  - the element index helper ((c*OY+y)*OX+x);
  - the state encoding (IDLE=1'b0, RUN=1'b1);
  - the pooled-count localparams OPX=OX/2 and OPY=OY/2.
- Sub-module `cnn_max4_relu`: purely combinational, four signed DATA_LEN inputs to one DATA_LEN output, implemented as a two-level compare tree plus a sign clamp.
- The top level holds the FSM, the buffer, the counters and the window-select mux.

## Test plan
- Reset: assert `reset` for 2 cycles → `o_in_ready`=1, `o_ot_valid`=0, `o_ot_data`=0, `o_busy`=0.
- Basic pooling:
  - Stimulus: ch0 elements (y*4+x) = 0..15, ch1 all −1; `i_ot_ready` held at 1.
  - Response: beats 5, 7, 13, 15, 0, 0, 0, 0 in consecutive cycles starting at N+1; `o_ot_last` only on beat 8; `o_in_ready`=1 in cycle N+9.
- Backpressure: same map with `i_ot_ready` toggling 1,0,0,1,... → identical 8-value sequence, data and last held stable during stalls, no beat lost or duplicated.
- Ignored input: pulse `i_in_valid` with a different map in RUN → output sequence unchanged; `o_in_ready`=0 throughout.
- Soft reset: assert `i_soft_reset` during beat 3 → `o_ot_valid`=0 next cycle; a new map then yields its correct first beat.
- Signed extremes: window {−524288, −1, −524288, −2} → 0; window {524287, −524288, 0, 1} → 524287.

Source files
------------

// File: rtl/cnn_pool_relu_stream_pkg.sv
// Shared definitions for the pooled ReLU output stream: state encoding,
// flattened element indexing and pooled-dimension helpers.
package cnn_pool_relu_stream_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Flat element index of (c,y,x) in a channel-major, row-major map.
  function automatic int unsigned elem_idx(input int unsigned c,
                                           input int unsigned y,
                                           input int unsigned x,
                                           input int unsigned oy,
                                           input int unsigned ox);
    return (c * oy + y) * ox + x;
  endfunction

  // Output extent of a 2x2 stride-2 pooling along one dimension (OPX/OPY).
  function automatic int unsigned pooled_dim(input int unsigned d);
    return d / 2;
  endfunction

  // Register width able to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_pool_relu_stream_max4_relu.sv
// Combinational max of four signed elements followed by a clamp at zero.
module cnn_max4_relu #(
  parameter int unsigned DATA_LEN = 20
) (
  input  logic [DATA_LEN-1:0] i_a,
  input  logic [DATA_LEN-1:0] i_b,
  input  logic [DATA_LEN-1:0] i_c,
  input  logic [DATA_LEN-1:0] i_d,
  output logic [DATA_LEN-1:0] o_y
);

  logic [DATA_LEN-1:0] w_m_ab;
  logic [DATA_LEN-1:0] w_m_cd;
  logic [DATA_LEN-1:0] w_m_all;

  // Two-level compare tree; selection only, so the most-negative value is safe.
  assign w_m_ab  = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
  assign w_m_cd  = ($signed(i_c) > $signed(i_d)) ? i_c : i_d;
  assign w_m_all = ($signed(w_m_ab) > $signed(w_m_cd)) ? w_m_ab : w_m_cd;

  assign o_y = w_m_all[DATA_LEN-1] ? '0 : w_m_all;

endmodule

// File: rtl/cnn_pool_relu_stream.sv
// Captures one flattened feature map, then streams its 2x2 max-pooled,
// ReLU'd elements channel-major over a valid/ready handshake.
module cnn_pool_relu_stream
  import cnn_pool_relu_stream_pkg::*;
#(
  parameter int unsigned OCH      = 2,
  parameter int unsigned OX       = 4,
  parameter int unsigned OY       = 4,
  parameter int unsigned DATA_LEN = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_soft_reset,
  input  logic                          i_in_valid,
  input  logic [OCH*OX*OY*DATA_LEN-1:0] i_in_fmap,
  output logic                          o_in_ready,
  output logic                          o_ot_valid,
  input  logic                          i_ot_ready,
  output logic [DATA_LEN-1:0]           o_ot_data,
  output logic                          o_ot_last,
  output logic                          o_busy
);

  localparam int unsigned OPX   = pooled_dim(OX);
  localparam int unsigned OPY   = pooled_dim(OY);
  localparam int unsigned NELEM = OCH * OX * OY;
  localparam int unsigned IW    = cnt_width(NELEM);
  localparam int unsigned CW_C  = cnt_width(OCH);
  localparam int unsigned CW_Y  = cnt_width(OPY);
  localparam int unsigned CW_X  = cnt_width(OPX);

  logic [0:0]          r_state;
  logic [CW_C-1:0]     r_c;
  logic [CW_Y-1:0]     r_py;
  logic [CW_X-1:0]     r_px;
  logic [DATA_LEN-1:0] r_buf [NELEM];

  logic [0:0]          w_state_nxt;
  logic [CW_C-1:0]     w_c_nxt;
  logic [CW_Y-1:0]     w_py_nxt;
  logic [CW_X-1:0]     w_px_nxt;
  logic                w_capture;
  logic                w_run;
  logic                w_last;
  logic [IW-1:0]       w_idx [4];
  logic [DATA_LEN-1:0] w_pooled;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = w_run && (r_c == CW_C'(OCH - 1)) &&
                  (r_py == CW_Y'(OPY - 1)) && (r_px == CW_X'(OPX - 1));

  // Next state and counters; a transfer on the last beat wraps all counters.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_py_nxt    = r_py;
    w_px_nxt    = r_px;
    w_capture   = 1'b0;
    if (r_state == ST_IDLE) begin
      if (i_in_valid) begin
        w_state_nxt = ST_RUN;
        w_capture   = 1'b1;
        w_c_nxt     = '0;
        w_py_nxt    = '0;
        w_px_nxt    = '0;
      end
    end else if (i_ot_ready) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
      end
      if (r_px == CW_X'(OPX - 1)) begin
        w_px_nxt = '0;
        if (r_py == CW_Y'(OPY - 1)) begin
          w_py_nxt = '0;
          w_c_nxt  = (r_c == CW_C'(OCH - 1)) ? '0 : r_c + CW_C'(1);
        end else begin
          w_py_nxt = r_py + CW_Y'(1);
        end
      end else begin
        w_px_nxt = r_px + CW_X'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_soft_reset) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_py    <= '0;
      r_px    <= '0;
      for (int i = 0; i < int'(NELEM); i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_py    <= w_py_nxt;
      r_px    <= w_px_nxt;
      if (w_capture) begin
        for (int i = 0; i < int'(NELEM); i++) begin
          r_buf[i] <= i_in_fmap[i*DATA_LEN +: DATA_LEN];
        end
      end
    end
  end

  // Window select: the four buffer elements under the current pooled position.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = IW'(elem_idx(32'(r_c),
                              2 * 32'(r_py) + 32'(k / 2),
                              2 * 32'(r_px) + 32'(k % 2),
                              OY, OX));
    end
  end

  cnn_max4_relu #(
    .DATA_LEN(DATA_LEN)
  ) u_max4_relu (
    .i_a(r_buf[w_idx[0]]),
    .i_b(r_buf[w_idx[1]]),
    .i_c(r_buf[w_idx[2]]),
    .i_d(r_buf[w_idx[3]]),
    .o_y(w_pooled)
  );

  assign o_in_ready = (r_state == ST_IDLE);
  assign o_busy     = w_run;
  assign o_ot_valid = w_run;
  assign o_ot_last  = w_last;
  assign o_ot_data  = w_run ? w_pooled : '0;

endmodule

// File: tb/tb_cnn_pool_relu_stream.sv
// Directed bench for cnn_pool_relu_stream with hand-computed pooled sequences.
module tb_cnn_pool_relu_stream;

  localparam int OCH = 2;
  localparam int OX  = 4;
  localparam int OY  = 4;
  localparam int DL  = 20;
  localparam int FW  = OCH * OX * OY * DL;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_soft_reset;
  logic          i_in_valid;
  logic [FW-1:0] i_in_fmap;
  logic          o_in_ready;
  logic          o_ot_valid;
  logic          i_ot_ready;
  logic [DL-1:0] o_ot_data;
  logic          o_ot_last;
  logic          o_busy;

  int checks   = 0;
  int failures = 0;

  int exp_basic [8] = '{5, 7, 13, 15, 0, 0, 0, 0};

  always #5 clk = ~clk;

  cnn_pool_relu_stream #(
    .OCH(OCH), .OX(OX), .OY(OY), .DATA_LEN(DL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_soft_reset(i_soft_reset),
    .i_in_valid(i_in_valid),
    .i_in_fmap(i_in_fmap),
    .o_in_ready(o_in_ready),
    .o_ot_valid(o_ot_valid),
    .i_ot_ready(i_ot_ready),
    .o_ot_data(o_ot_data),
    .o_ot_last(o_ot_last),
    .o_busy(o_busy)
  );

  // ch0 element (y,x) = base + y*4 + x, ch1 all -1
  function automatic logic [FW-1:0] map_ramp(input int base);
    logic [FW-1:0] m;
    int v;
    m = '0;
    for (int c = 0; c < OCH; c++)
      for (int y = 0; y < OY; y++)
        for (int x = 0; x < OX; x++) begin
          v = (c == 0) ? base + y * 4 + x : -1;
          m[((c * OY + y) * OX + x) * DL +: DL] = DL'(v);
        end
    return m;
  endfunction

  function automatic logic [FW-1:0] map_extreme();
    logic [FW-1:0] m;
    m = '0;
    m[((0 * OY + 0) * OX + 0) * DL +: DL] = DL'(-524288);
    m[((0 * OY + 0) * OX + 1) * DL +: DL] = DL'(-1);
    m[((0 * OY + 1) * OX + 0) * DL +: DL] = DL'(-524288);
    m[((0 * OY + 1) * OX + 1) * DL +: DL] = DL'(-2);
    m[((0 * OY + 0) * OX + 2) * DL +: DL] = DL'(524287);
    m[((0 * OY + 0) * OX + 3) * DL +: DL] = DL'(-524288);
    m[((0 * OY + 1) * OX + 2) * DL +: DL] = DL'(0);
    m[((0 * OY + 1) * OX + 3) * DL +: DL] = DL'(1);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a map for one cycle; returns one step after the capture edge.
  task automatic send_map(input logic [FW-1:0] m);
    i_in_fmap  = m;
    i_in_valid = 1'b1;
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_in_valid = 1'b1; i_in_fmap = map_ramp(0);
    step(); step();
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
    checks++; if (o_ot_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_ot_valid); end
    checks++; if (o_ot_data !== '0) begin failures++; $display("FAIL reset_data got=%0d exp=0", o_ot_data); end
    checks++; if (o_busy !== 1'b0 || o_ot_last !== 1'b0) begin failures++; $display("FAIL reset_busy_last got=%b%b exp=00", o_busy, o_ot_last); end
    reset = 1'b0; i_in_valid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    i_ot_ready = 1'b1;
    send_map(map_ramp(0));
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (o_ot_valid !== 1'b1 || o_ot_data !== DL'(exp_basic[k]) || o_ot_last !== (k == 7) || o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL basic_beat%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b", k, o_ot_valid, o_ot_data, o_ot_last, exp_basic[k], k == 7);
      end
      step();
    end
    checks++; if (o_in_ready !== 1'b1 || o_ot_valid !== 1'b0) begin failures++; $display("FAIL basic_return got rdy=%b v=%b exp rdy=1 v=0", o_in_ready, o_ot_valid); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int cyc = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_map(map_ramp(0));
    while (k < 8 && cyc < 100) begin
      i_ot_ready = pat[cyc % 4];
      checks++;
      if (o_ot_valid !== 1'b1 || o_ot_data !== DL'(exp_basic[k]) || o_ot_last !== (k == 7)) begin
        failures++;
        $display("FAIL bp_cyc%0d_beat%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b", cyc, k, o_ot_valid, o_ot_data, o_ot_last, exp_basic[k], k == 7);
      end
      step();
      if (i_ot_ready) k++;
      cyc++;
    end
    i_ot_ready = 1'b1;
    checks++; if (k != 8 || o_in_ready !== 1'b1) begin failures++; $display("FAIL bp_done got beats=%0d rdy=%b exp beats=8 rdy=1", k, o_in_ready); end
  endtask

  task automatic test_ignored_input();
    i_ot_ready = 1'b1;
    send_map(map_ramp(0));
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin i_in_valid = 1'b1; i_in_fmap = map_ramp(100); end
      else        i_in_valid = 1'b0;
      checks++;
      if (o_ot_data !== DL'(exp_basic[k]) || o_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL ign_beat%0d got d=%0d rdy=%b exp d=%0d rdy=0", k, o_ot_data, o_in_ready, exp_basic[k]);
      end
      step();
    end
    i_in_valid = 1'b0;
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL ign_return got rdy=%b exp=1", o_in_ready); end
  endtask

  task automatic test_soft_reset();
    i_ot_ready = 1'b1;
    send_map(map_ramp(0));
    step(); step();
    checks++; if (o_ot_data !== DL'(13)) begin failures++; $display("FAIL sr_beat3 got=%0d exp=13", o_ot_data); end
    i_soft_reset = 1'b1;
    step();
    i_soft_reset = 1'b0;
    checks++; if (o_ot_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL sr_idle got v=%b rdy=%b busy=%b exp 0 1 0", o_ot_valid, o_in_ready, o_busy); end
    send_map(map_ramp(100));
    checks++; if (o_ot_valid !== 1'b1 || o_ot_data !== DL'(105)) begin failures++; $display("FAIL sr_newmap got v=%b d=%0d exp v=1 d=105", o_ot_valid, o_ot_data); end
    step();
    checks++; if (o_ot_data !== DL'(107)) begin failures++; $display("FAIL sr_newmap2 got=%0d exp=107", o_ot_data); end
    for (int k = 0; k < 20 && o_ot_valid; k++) step();
  endtask

  task automatic test_signed_extremes();
    i_ot_ready = 1'b0;
    send_map(map_extreme());
    checks++; if (o_ot_data !== DL'(0)) begin failures++; $display("FAIL ext_neg got=%0d exp=0", o_ot_data); end
    i_ot_ready = 1'b1;
    step();
    checks++; if (o_ot_data !== DL'(524287)) begin failures++; $display("FAIL ext_max got=%0d exp=524287", o_ot_data); end
    for (int k = 0; k < 20 && o_ot_valid; k++) step();
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL ext_drain got rdy=%b exp=1", o_in_ready); end
  endtask

  initial begin
    reset = 1'b1; i_soft_reset = 1'b0; i_in_valid = 1'b0;
    i_in_fmap = '0; i_ot_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_input();
    test_soft_reset();
    test_signed_extremes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
